// File: rtl/rob_tag_ctrl_pkg.sv
// rob_tag_ctrl_pkg: shared constants and types for the ROB tag controller.
// It provides the tag, register-index, ring-pointer and count types, the
// RUN/FLUSH state encoding, and a helper that zero-extends a slot index to a tag.
package rob_tag_ctrl_pkg;

  localparam int unsigned ROB_DEPTH = 16;
  localparam int unsigned TAG_W     = 6;
  localparam int unsigned REG_NUM   = 32;
  localparam int unsigned PTR_W     = $clog2(ROB_DEPTH);
  localparam int unsigned RIDX_W    = $clog2(REG_NUM);
  localparam int unsigned CNT_W     = PTR_W + 1;

  typedef logic [TAG_W-1:0]  tag_t;
  typedef logic [RIDX_W-1:0] ridx_t;
  typedef logic [PTR_W-1:0]  ptr_t;
  typedef logic [CNT_W-1:0]  cnt_t;

  // "No pending producer" encoding. It lies outside the 0..15 slot range.
  localparam tag_t  INVALID_TAG = 6'b010000;
  localparam ridx_t LAST_REG    = ridx_t'(REG_NUM - 1);

  typedef enum logic {
    RUN   = 1'b0,
    FLUSH = 1'b1
  } state_e;

  function automatic tag_t ptr2tag(input ptr_t p);
    return tag_t'(p);
  endfunction

endpackage

// File: rtl/rob_tag_ctrl_if.sv
// rob_tag_ctrl_if: bundles the issue, commit, flush and status-table signals
// of rob_tag_ctrl.
//   master : the environment side (issue stage, commit logic, status table)
//   slave  : rob_tag_ctrl itself
interface rob_tag_ctrl_if;
  import rob_tag_ctrl_pkg::*;

  logic  issue_valid;
  logic  issue_has_dest;
  ridx_t issue_dest;
  logic  issue_ready;
  tag_t  issue_tag;
  logic  commit_valid;
  tag_t  commit_tag;
  logic  flush;
  logic  flush_busy;
  cnt_t  count;
  ridx_t rs_lookup_reg;
  tag_t  rs_lookup_tag;
  logic  rs_we;
  ridx_t rs_widx;
  tag_t  rs_wdata;

  modport master (
    output issue_valid, issue_has_dest, issue_dest, commit_valid, flush,
           rs_lookup_tag,
    input  issue_ready, issue_tag, commit_tag, flush_busy, count,
           rs_lookup_reg, rs_we, rs_widx, rs_wdata
  );

  modport slave (
    input  issue_valid, issue_has_dest, issue_dest, commit_valid, flush,
           rs_lookup_tag,
    output issue_ready, issue_tag, commit_tag, flush_busy, count,
           rs_lookup_reg, rs_we, rs_widx, rs_wdata
  );

endinterface

// File: rtl/rob_tag_ring.sv
// rob_tag_ring: the circular tag allocator. It holds the head and tail
// pointers, the occupancy count, and the destination register plus the
// has-destination flag of each slot.
//   clear          : resets the pointers and the count (flush)
//   push / pop     : allocate at the tail / retire at the head
//   push_has_dest,
//   push_dest      : destination information stored in the tail slot on push
//   head, tail     : slot indices; they wrap 15 -> 0
//   count          : occupied slots, 0..16
//   head_dest,
//   head_has_dest  : destination information of the head slot
module rob_tag_ring
  import rob_tag_ctrl_pkg::*;
(
  input  logic  clk,
  input  logic  rst_n,
  input  logic  clear,
  input  logic  push,
  input  logic  push_has_dest,
  input  ridx_t push_dest,
  input  logic  pop,
  output ptr_t  head,
  output ptr_t  tail,
  output cnt_t  count,
  output ridx_t head_dest,
  output logic  head_has_dest
);

  ridx_t                slot_dest [ROB_DEPTH];
  logic [ROB_DEPTH-1:0] slot_hd;

  // The pointer width equals log2(ROB_DEPTH), so the increment wraps on its own.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else if (clear) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (push) tail <= tail + ptr_t'(1);
      if (pop)  head <= head + ptr_t'(1);
      case ({push, pop})
        2'b10:   count <= count + cnt_t'(1);
        2'b01:   count <= count - cnt_t'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < ROB_DEPTH; i++) slot_dest[i] <= '0;
      slot_hd <= '0;
    end else if (push) begin
      slot_dest[tail] <= push_dest;
      slot_hd[tail]   <= push_has_dest;
    end
  end

  assign head_dest     = slot_dest[head];
  assign head_has_dest = slot_hd[head];

endmodule

// File: rtl/rob_tag_ctrl.sv
// rob_tag_ctrl: allocates ROB tags at issue and drives every write into the
// register status table through one registered write port.
//   clk, rst_n : clock (rising edge) and asynchronous active-low reset
//   bus        : issue / commit / flush handshake and status-table ports
//                (rob_tag_ctrl_if.slave)
// An issue writes its tag as the producer of its destination register. A
// commit clears the destination register only while that register still holds
// the committing tag. A flush walks registers 1..31 back to INVALID_TAG.
module rob_tag_ctrl
  import rob_tag_ctrl_pkg::*;
(
  input  logic           clk,
  input  logic           rst_n,
  rob_tag_ctrl_if.slave  bus
);

  state_e state, state_n;

  ptr_t  head, tail;
  cnt_t  count;
  ridx_t head_dest;
  logic  head_has_dest;

  logic  commit_ok, clear_needed, issue_writes, port_conflict;
  logic  issue_ready, issue_acc;

  logic  we_q, we_n;
  ridx_t widx_q, widx_n;
  tag_t  wdata_q, wdata_n;

  rob_tag_ring u_ring (
    .clk           (clk),
    .rst_n         (rst_n),
    .clear         (bus.flush),
    .push          (issue_acc),
    .push_has_dest (bus.issue_has_dest),
    .push_dest     (bus.issue_dest),
    .pop           (commit_ok),
    .head          (head),
    .tail          (tail),
    .count         (count),
    .head_dest     (head_dest),
    .head_has_dest (head_has_dest)
  );

  assign commit_ok    = (state == RUN) && !bus.flush && bus.commit_valid &&
                        (count != '0);
  assign clear_needed = (count != '0) && head_has_dest && (head_dest != '0) &&
                        (bus.rs_lookup_tag == ptr2tag(head));
  assign issue_writes = bus.issue_has_dest && (bus.issue_dest != '0);

  // A same-register issue supersedes the clear, so only a different register
  // competes with the commit for the single write port.
  assign port_conflict = commit_ok && clear_needed && issue_writes &&
                         (bus.issue_dest != head_dest);

  assign issue_ready = (state == RUN) && !bus.flush &&
                       (count < cnt_t'(ROB_DEPTH)) && !port_conflict;
  assign issue_acc   = bus.issue_valid && issue_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= RUN;
      we_q    <= 1'b0;
      widx_q  <= '0;
      wdata_q <= INVALID_TAG;
    end else begin
      state   <= state_n;
      we_q    <= we_n;
      widx_q  <= widx_n;
      wdata_q <= wdata_n;
    end
  end

  // In FLUSH, the write-index register is also the walk counter. A flush
  // loads index 1 and each FLUSH cycle advances it until register 31 is written.
  always_comb begin
    state_n = state;
    we_n    = 1'b0;
    widx_n  = widx_q;
    wdata_n = wdata_q;
    if (bus.flush) begin
      state_n = FLUSH;
      we_n    = 1'b1;
      widx_n  = ridx_t'(1);
      wdata_n = INVALID_TAG;
    end else if (state == FLUSH) begin
      if (widx_q == LAST_REG) begin
        state_n = RUN;
      end else begin
        we_n    = 1'b1;
        widx_n  = widx_q + ridx_t'(1);
        wdata_n = INVALID_TAG;
      end
    end else if (issue_acc && issue_writes) begin
      we_n    = 1'b1;
      widx_n  = bus.issue_dest;
      wdata_n = ptr2tag(tail);
    end else if (commit_ok && clear_needed) begin
      we_n    = 1'b1;
      widx_n  = head_dest;
      wdata_n = INVALID_TAG;
    end
  end

  assign bus.issue_ready   = issue_ready;
  assign bus.issue_tag     = ptr2tag(tail);
  assign bus.commit_tag    = ptr2tag(head);
  assign bus.flush_busy    = (state == FLUSH);
  assign bus.count         = count;
  assign bus.rs_lookup_reg = head_dest;
  assign bus.rs_we         = we_q;
  assign bus.rs_widx       = widx_q;
  assign bus.rs_wdata      = wdata_q;

endmodule

// File: tb/tb_rob_tag_ctrl.sv
// tb_rob_tag_ctrl: self-checking bench for rob_tag_ctrl. It models the
// register status table, predicts every status-table write into a scoreboard
// queue, and checks the handshake outputs directly.
module tb_rob_tag_ctrl;
  import rob_tag_ctrl_pkg::*;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  rob_tag_ctrl_if bus ();

  rob_tag_ctrl dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Status-table model; the DUT reads it combinationally.
  tag_t stab [REG_NUM];
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 32; i++) stab[i] <= INVALID_TAG;
    end else if (bus.rs_we) begin
      stab[bus.rs_widx] <= bus.rs_wdata;
    end
  end
  assign bus.rs_lookup_tag = stab[bus.rs_lookup_reg];

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int unsigned nvec = 0;
  int unsigned nerr = 0;

  task automatic chk(input string tag, input int unsigned got, input int unsigned exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  typedef struct {
    logic [4:0]  idx;
    logic [5:0]  data;
    int unsigned cyc;
  } wr_t;
  wr_t sb[$];

  task automatic expect_wr(input logic [4:0] idx, input logic [5:0] data,
                           input int unsigned dly);
    sb.push_back('{idx: idx, data: data, cyc: cyc + dly});
  endtask

  always @(negedge clk) begin : mon
    wr_t e;
    if (rst_n) begin
      while (sb.size() > 0 && sb[0].cyc < cyc) begin
        chk("we_missing", 0, 1);
        void'(sb.pop_front());
      end
      if (bus.rs_we) begin
        chk("we_idx_nonzero", 32'(bus.rs_widx != '0), 1);
        if (sb.size() == 0) begin
          chk("we_unexpected", 1, 0);
        end else begin
          e = sb.pop_front();
          chk("we_idx",  32'(bus.rs_widx),  32'(e.idx));
          chk("we_data", 32'(bus.rs_wdata), 32'(e.data));
          chk("we_cyc",  cyc, e.cyc);
        end
      end
    end
  end

  task automatic drive(input logic iv, input logic hd, input logic [4:0] d,
                       input logic cv, input logic fl);
    bus.issue_valid    = iv;
    bus.issue_has_dest = hd;
    bus.issue_dest     = d;
    bus.commit_valid   = cv;
    bus.flush          = fl;
    #1;
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset_vals(input string pfx);
    chk({pfx, "_count"}, 32'(bus.count), 0);
    chk({pfx, "_we"},    32'(bus.rs_we), 0);
    chk({pfx, "_widx"},  32'(bus.rs_widx), 0);
    chk({pfx, "_wdata"}, 32'(bus.rs_wdata), 16);
    chk({pfx, "_busy"},  32'(bus.flush_busy), 0);
    chk({pfx, "_itag"},  32'(bus.issue_tag), 0);
    chk({pfx, "_ctag"},  32'(bus.commit_tag), 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    drive(0, 0, 0, 0, 0);
    repeat (2) tick;
    chk_reset_vals("rst");
    rst_n = 1'b1;
    tick;

    // Fill all 16 slots with dest 1..16.
    for (int i = 0; i < 16; i++) begin
      drive(1, 1, 5'(i + 1), 0, 0);
      chk("fill_ready", 32'(bus.issue_ready), 1);
      chk("fill_tag",   32'(bus.issue_tag), i);
      expect_wr(5'(i + 1), 6'(i), 1);
      tick;
    end
    drive(1, 1, 5'd17, 0, 0);
    chk("full_count", 32'(bus.count), 16);
    chk("full_ready", 32'(bus.issue_ready), 0);

    // Full: commit and issue in the same cycle. The commit retires; the issue stalls.
    drive(1, 1, 5'd20, 1, 0);
    chk("fc_ready",  32'(bus.issue_ready), 0);
    chk("fc_ctag",   32'(bus.commit_tag), 0);
    chk("fc_lookup", 32'(bus.rs_lookup_reg), 1);
    expect_wr(5'd1, 6'd16, 1);
    tick;
    drive(1, 1, 5'd20, 0, 0);
    chk("fc_count",   32'(bus.count), 15);
    chk("wrap_ready", 32'(bus.issue_ready), 1);
    chk("wrap_tag",   32'(bus.issue_tag), 0);
    expect_wr(5'd20, 6'd0, 1);
    tick;

    // Drain to 9 entries. Each commit clears its own register.
    for (int h = 1; h <= 7; h++) begin
      drive(0, 0, 0, 1, 0);
      chk("drain_ctag", 32'(bus.commit_tag), h);
      expect_wr(5'(h + 1), 6'd16, 1);
      tick;
    end

    // Flush with 9 entries in flight; issue and commit in the flush cycle are ignored.
    drive(1, 1, 5'd7, 1, 1);
    chk("preflush_count", 32'(bus.count), 9);
    chk("flush_ready0",   32'(bus.issue_ready), 0);
    for (int i = 1; i <= 31; i++) expect_wr(5'(i), 6'd16, i);
    tick;
    for (int i = 1; i <= 31; i++) begin
      drive(1, 1, 5'd7, 1, 0);
      chk("flush_busy",  32'(bus.flush_busy), 1);
      chk("flush_ready", 32'(bus.issue_ready), 0);
      chk("flush_count", 32'(bus.count), 0);
      tick;
    end
    drive(0, 0, 0, 0, 0);
    chk("flush_done", 32'(bus.flush_busy), 0);

    // Commit of a superseded producer leaves the register alone.
    drive(1, 1, 5'd5, 0, 0);
    chk("pf_ready", 32'(bus.issue_ready), 1);
    chk("pf_tag",   32'(bus.issue_tag), 0);
    expect_wr(5'd5, 6'd0, 1);
    tick;
    drive(1, 1, 5'd5, 0, 0);
    chk("r5b_tag", 32'(bus.issue_tag), 1);
    expect_wr(5'd5, 6'd1, 1);
    tick;
    drive(0, 0, 0, 0, 0);
    tick;
    drive(0, 0, 0, 1, 0);
    chk("sup_ctag",   32'(bus.commit_tag), 0);
    chk("sup_lookup", 32'(bus.rs_lookup_reg), 5);
    tick;
    drive(0, 0, 0, 1, 0);
    chk("clr_ctag", 32'(bus.commit_tag), 1);
    expect_wr(5'd5, 6'd16, 1);
    tick;
    drive(0, 0, 0, 0, 0);
    chk("clr_count", 32'(bus.count), 0);

    // A commit clearing r3 wins the port over an issue to r7.
    drive(1, 1, 5'd3, 0, 0);
    chk("r3_tag", 32'(bus.issue_tag), 2);
    expect_wr(5'd3, 6'd2, 1);
    tick;
    drive(0, 0, 0, 0, 0);
    tick;
    drive(1, 1, 5'd7, 1, 0);
    chk("conf_ready", 32'(bus.issue_ready), 0);
    chk("conf_ctag",  32'(bus.commit_tag), 2);
    expect_wr(5'd3, 6'd16, 1);
    tick;
    drive(0, 0, 0, 0, 0);
    chk("conf_count", 32'(bus.count), 0);
    chk("conf_itag",  32'(bus.issue_tag), 3);

    // An issue to the committing register proceeds; only its write happens.
    drive(1, 1, 5'd3, 0, 0);
    expect_wr(5'd3, 6'd3, 1);
    tick;
    drive(0, 0, 0, 0, 0);
    tick;
    drive(1, 1, 5'd3, 1, 0);
    chk("same_ready", 32'(bus.issue_ready), 1);
    chk("same_itag",  32'(bus.issue_tag), 4);
    chk("same_ctag",  32'(bus.commit_tag), 3);
    expect_wr(5'd3, 6'd4, 1);
    tick;
    drive(0, 0, 0, 0, 0);
    chk("same_count", 32'(bus.count), 1);

    // Dest 0 and no-dest issues consume slots without writing.
    drive(1, 1, 5'd0, 0, 0);
    chk("d0_ready", 32'(bus.issue_ready), 1);
    chk("d0_tag",   32'(bus.issue_tag), 5);
    tick;
    drive(1, 0, 5'd9, 0, 0);
    chk("nd_tag", 32'(bus.issue_tag), 6);
    tick;
    drive(0, 0, 0, 0, 0);
    chk("d0_count", 32'(bus.count), 3);

    // Reset while the flush walk is at index 12.
    drive(0, 0, 0, 0, 1);
    for (int i = 1; i <= 11; i++) expect_wr(5'(i), 6'd16, i);
    tick;
    drive(0, 0, 0, 0, 0);
    repeat (11) tick;
    chk("mid_we",   32'(bus.rs_we), 1);
    chk("mid_widx", 32'(bus.rs_widx), 12);
    rst_n = 1'b0;
    #1;
    chk_reset_vals("abort");
    repeat (3) tick;
    rst_n = 1'b1;
    repeat (5) tick;
    chk("post_busy",  32'(bus.flush_busy), 0);
    chk("post_count", 32'(bus.count), 0);
    chk("sb_empty",   sb.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
